// File: rtl/event_byte_serializer_if.sv
// ----------------------------------------------------------------------------
// event_byte_serializer_if
// Purpose : bundles the event-tuple input handshake and the byte-stream output
//           handshake of the event byte serializer.
// Signals :
//   in_valid / in_ready : tuple handshake (producer -> serializer)
//   x, y, t (16b), p    : event tuple
//   out_valid/out_ready : byte handshake (serializer -> downstream)
//   out_data (8b)       : packet byte
//   out_last            : marks the final byte of a packet
// Modports:
//   slave  : the serializer's view
//   master : the surrounding logic's view (drives tuple and out_ready)
// ----------------------------------------------------------------------------
interface event_byte_serializer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] t;
  logic        p;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  modport slave (
    input  in_valid, x, y, t, p, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, x, y, t, p, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/event_byte_serializer.sv
// ----------------------------------------------------------------------------
// event_byte_serializer
// Purpose : accepts one event tuple {x,y,t,p} and emits it as a framed byte
//           packet: header {HDR_SYNC,p}, x, y, t (MSB first), then an optional
//           XOR checksum of the seven preceding bytes.
// Ports   :
//   clk        system clock, all state on rising edge
//   rst        asynchronous, active-high reset
//   bus        event_byte_serializer_if.slave (tuple in, byte stream out)
//   busy       packet in flight
//   pkt_count  packets fully transmitted, wraps 16'hFFFF -> 0
// ----------------------------------------------------------------------------
module event_byte_serializer #(
  parameter logic [6:0] HDR_SYNC    = 7'h55,
  parameter bit         EN_CHECKSUM = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  event_byte_serializer_if.slave   bus,
  output logic                     busy,
  output logic [15:0]              pkt_count
);

  // Index of the final byte: 7 with checksum, 6 without.
  localparam logic [2:0] LAST_IDX = EN_CHECKSUM ? 3'd7 : 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [48:0] r_tuple;      // {x[48:33], y[32:17], t[16:1], p[0]}
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        r_out_last;
  logic        r_busy;
  logic [15:0] r_pkt_count;

  logic [48:0] w_in_tuple;
  logic        w_last_take;
  logic        w_in_ready;
  logic        w_accept;

  // XOR of header and the six coordinate/timestamp bytes of a tuple.
  function automatic logic [7:0] tuple_checksum(input logic [48:0] tup);
    return {HDR_SYNC, tup[0]} ^ tup[48:41] ^ tup[40:33] ^ tup[32:25] ^
           tup[24:17] ^ tup[16:9] ^ tup[8:1];
  endfunction

  // Byte map of a packet, selected by byte index.
  function automatic logic [7:0] tuple_byte(input logic [48:0] tup,
                                            input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {HDR_SYNC, tup[0]};
      3'd1:    b = tup[48:41];
      3'd2:    b = tup[40:33];
      3'd3:    b = tup[32:25];
      3'd4:    b = tup[24:17];
      3'd5:    b = tup[16:9];
      3'd6:    b = tup[8:1];
      3'd7:    b = tuple_checksum(tup);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign w_in_tuple  = {bus.x, bus.y, bus.t, bus.p};
  // Final byte is leaving this cycle, so a new tuple can be taken without a bubble.
  assign w_last_take = (r_state == ST_SEND) && (r_idx == LAST_IDX) && bus.out_ready;
  // Combinational out_ready -> in_ready path; forced low while reset is held.
  assign w_in_ready  = !rst && ((r_state == ST_IDLE) || w_last_take);
  assign w_accept    = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign busy          = r_busy;
  assign pkt_count     = r_pkt_count;

  // Packet FSM: tuple capture, byte sequencing and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= 3'd0;
      r_tuple     <= 49'd0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_pkt_count <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tuple     <= w_in_tuple;
            r_state     <= ST_SEND;
            r_idx       <= 3'd0;
            r_out_data  <= tuple_byte(w_in_tuple, 3'd0);
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b1;
          end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
          end
        end

        ST_SEND: begin
          // Without out_ready everything holds, keeping the byte stable under stall.
          if (bus.out_ready) begin
            if (r_idx == LAST_IDX) begin
              r_pkt_count <= r_pkt_count + 16'd1;
              if (w_accept) begin
                // Back-to-back: next packet header follows directly.
                r_tuple     <= w_in_tuple;
                r_idx       <= 3'd0;
                r_out_data  <= tuple_byte(w_in_tuple, 3'd0);
                r_out_valid <= 1'b1;
                r_out_last  <= 1'b0;
                r_busy      <= 1'b1;
              end else begin
                r_state     <= ST_IDLE;
                r_idx       <= 3'd0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_busy      <= 1'b0;
              end
            end else begin
              r_idx       <= r_idx + 3'd1;
              r_out_data  <= tuple_byte(r_tuple, r_idx + 3'd1);
              r_out_last  <= ((r_idx + 3'd1) == LAST_IDX);
            end
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_idx       <= 3'd0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_byte_serializer.sv
module tb_event_byte_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  event_byte_serializer_if ifa ();
  event_byte_serializer_if ifb ();
  logic        busy_a, busy_b;
  logic [15:0] cnt_a, cnt_b;

  event_byte_serializer dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .busy(busy_a), .pkt_count(cnt_a)
  );

  event_byte_serializer #(.HDR_SYNC(7'h55), .EN_CHECKSUM(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .busy(busy_b), .pkt_count(cnt_b)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] ev_x [8];
  logic [15:0] ev_y [8];
  logic [15:0] ev_t [8];
  logic        ev_p [8];

  logic [255:0] cap_vec, exp_vec;
  logic [31:0]  cap_last_vec, exp_last_vec;
  int cap_n, exp_n;
  int stall_err, irdy_err, valid_cycles, irdy_pulses, lat_first, span;
  bit timeout;

  // Reference packet byte straight from the packet format definition.
  function automatic logic [7:0] model_byte(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] t, input logic p, input int i);
    logic [7:0] b [8];
    b[0] = 8'((16'h0055 << 1) | {15'd0, p});
    b[1] = 8'(x >> 8);  b[2] = 8'(x & 16'h00FF);
    b[3] = 8'(y >> 8);  b[4] = 8'(y & 16'h00FF);
    b[5] = 8'(t >> 8);  b[6] = 8'(t & 16'h00FF);
    b[7] = 8'h00;
    for (int j = 0; j < 7; j++) b[7] = b[7] ^ b[j];
    return b[i];
  endfunction

  task automatic build_exp(input int n, input int plen);
    exp_vec = '0; exp_last_vec = '0; exp_n = 0;
    for (int e = 0; e < n; e++)
      for (int i = 0; i < plen; i++) begin
        exp_vec[exp_n*8 +: 8] = model_byte(ev_x[e], ev_y[e], ev_t[e], ev_p[e], i);
        exp_last_vec[exp_n]   = (i == plen - 1);
        exp_n++;
      end
  endtask

  task automatic rand_events(input int n);
    for (int e = 0; e < n; e++) begin
      ev_x[e] = 16'($urandom); ev_y[e] = 16'($urandom);
      ev_t[e] = 16'($urandom); ev_p[e] = 1'($urandom);
    end
  endtask

  // Drives n events into dut_a, random out_ready, captures handshaken bytes.
  task automatic drive_a(input int n, input int ready_pct);
    int k, lasts, cyc, first_cyc, last_cyc, acc0_cyc;
    bit pend, ov, ol, prev_stall, prev_l;
    logic [7:0] od, prev_d;
    cap_vec = '0; cap_last_vec = '0; cap_n = 0;
    stall_err = 0; irdy_err = 0; valid_cycles = 0; irdy_pulses = 0; timeout = 1'b0;
    k = 0; lasts = 0; cyc = 0; first_cyc = -1; last_cyc = -1; acc0_cyc = -1;
    pend = 1'b0; prev_stall = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
    @(negedge clk);
    ifa.in_valid = 1'b1;
    ifa.x = ev_x[0]; ifa.y = ev_y[0]; ifa.t = ev_t[0]; ifa.p = ev_p[0];
    forever begin
      if (pend) begin
        pend = 1'b0;
        k++;
        if (k < n) begin
          ifa.x = ev_x[k]; ifa.y = ev_y[k]; ifa.t = ev_t[k]; ifa.p = ev_p[k];
        end else begin
          ifa.in_valid = 1'b0;
          ifa.x = 16'($urandom); ifa.y = 16'($urandom); ifa.t = 16'($urandom);
        end
      end
      ov = ifa.out_valid; od = ifa.out_data; ol = ifa.out_last;
      if (prev_stall && (od !== prev_d || ol !== prev_l)) stall_err++;
      if (ov) begin
        valid_cycles++;
        if (first_cyc < 0) first_cyc = cyc;
      end
      ifa.out_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      if (ifa.in_ready !== (!ov || (ol && ifa.out_ready))) irdy_err++;
      if (ov && ifa.in_ready) irdy_pulses++;
      if (ifa.in_valid && ifa.in_ready) begin
        pend = 1'b1;
        if (acc0_cyc < 0) acc0_cyc = cyc;
      end
      if (ov && ifa.out_ready) begin
        if (cap_n < 32) begin
          cap_vec[cap_n*8 +: 8] = od;
          cap_last_vec[cap_n]   = ol;
        end
        cap_n++;
        if (ol) begin lasts++; last_cyc = cyc; end
      end
      prev_stall = ov && !ifa.out_ready; prev_d = od; prev_l = ol;
      if (lasts >= n) break;
      if (cyc >= 3000) begin timeout = 1'b1; break; end
      cyc++;
      @(negedge clk);
    end
    @(negedge clk);
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
    lat_first = first_cyc - acc0_cyc;
    span = last_cyc - first_cyc + 1;
  endtask

  task automatic test_reset();
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b0; ifa.x = 16'd0; ifa.y = 16'd0; ifa.t = 16'd0; ifa.p = 1'b0;
    ifb.in_valid = 1'b0; ifb.out_ready = 1'b0; ifb.x = 16'd0; ifb.y = 16'd0; ifb.t = 16'd0; ifb.p = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ifa.out_valid); end
    checks++; if (ifa.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", ifa.out_data); end
    checks++; if (cnt_a !== 16'd0) begin failures++; $display("FAIL reset_pkt_count got=%0d exp=0", cnt_a); end
    checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", ifa.in_ready); end
    checks++; if (busy_a !== 1'b0 || ifa.out_last !== 1'b0) begin failures++; $display("FAIL reset_busy_last got=%b%b exp=00", busy_a, ifa.out_last); end
    rst = 1'b0;
    #1;
    checks++; if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b%b exp=11", ifa.in_ready, ifb.in_ready); end
  endtask

  task automatic test_single();
    logic [15:0] c0;
    ev_x[0] = 16'h1234; ev_y[0] = 16'hABCD; ev_t[0] = 16'h0F0F; ev_p[0] = 1'b1;
    c0 = cnt_a;
    drive_a(1, 100);
    build_exp(1, 8);
    checks++; if (timeout) begin failures++; $display("FAIL single_timeout got=1 exp=0"); end
    checks++; if (cap_n != 8) begin failures++; $display("FAIL single_nbytes got=%0d exp=8", cap_n); end
    checks++; if (cap_vec[63:0] !== 64'hEB0F_0FCD_AB34_12AB) begin failures++; $display("FAIL single_bytes_const got=%h exp=eb0f0fcdab3412ab", cap_vec[63:0]); end
    checks++; if (cap_vec !== exp_vec) begin failures++; $display("FAIL single_bytes got=%h exp=%h", cap_vec, exp_vec); end
    checks++; if (cap_last_vec !== exp_last_vec) begin failures++; $display("FAIL single_last got=%h exp=%h", cap_last_vec, exp_last_vec); end
    checks++; if (lat_first != 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", lat_first); end
    checks++; if (cnt_a !== 16'(c0 + 16'd1)) begin failures++; $display("FAIL single_pkt_count got=%0d exp=%0d", cnt_a, 16'(c0 + 16'd1)); end
  endtask

  task automatic test_backpressure();
    logic [15:0] c0;
    ev_x[0] = 16'h1234; ev_y[0] = 16'hABCD; ev_t[0] = 16'h0F0F; ev_p[0] = 1'b1;
    c0 = cnt_a;
    drive_a(1, 50);
    build_exp(1, 8);
    checks++; if (timeout) begin failures++; $display("FAIL bp_timeout got=1 exp=0"); end
    checks++; if (cap_vec !== exp_vec || cap_n != 8) begin failures++; $display("FAIL bp_bytes got=%h n=%0d exp=%h", cap_vec, cap_n, exp_vec); end
    checks++; if (cap_last_vec !== exp_last_vec) begin failures++; $display("FAIL bp_last got=%h exp=%h", cap_last_vec, exp_last_vec); end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_err); end
    checks++; if (irdy_err != 0) begin failures++; $display("FAIL bp_in_ready got=%0d exp=0", irdy_err); end
    checks++; if (cnt_a !== 16'(c0 + 16'd1)) begin failures++; $display("FAIL bp_pkt_count got=%0d exp=%0d", cnt_a, 16'(c0 + 16'd1)); end
  endtask

  task automatic test_random();
    logic [15:0] c0;
    for (int r = 0; r < 3; r++) begin
      rand_events(4);
      c0 = cnt_a;
      drive_a(4, int'($urandom_range(30, 90)));
      build_exp(4, 8);
      checks++; if (timeout) begin failures++; $display("FAIL rand_timeout round=%0d got=1 exp=0", r); end
      checks++; if (cap_vec !== exp_vec || cap_n != 32) begin failures++; $display("FAIL rand_bytes round=%0d got=%h n=%0d exp=%h", r, cap_vec, cap_n, exp_vec); end
      checks++; if (cap_last_vec !== exp_last_vec) begin failures++; $display("FAIL rand_last round=%0d got=%h exp=%h", r, cap_last_vec, exp_last_vec); end
      checks++; if (stall_err != 0 || irdy_err != 0) begin failures++; $display("FAIL rand_stall_ready round=%0d got=%0d/%0d exp=0/0", r, stall_err, irdy_err); end
      checks++; if (cnt_a !== 16'(c0 + 16'd4)) begin failures++; $display("FAIL rand_pkt_count round=%0d got=%0d exp=%0d", r, cnt_a, 16'(c0 + 16'd4)); end
    end
  endtask

  task automatic test_back_to_back();
    rand_events(3);
    drive_a(3, 100);
    build_exp(3, 8);
    checks++; if (timeout) begin failures++; $display("FAIL b2b_timeout got=1 exp=0"); end
    checks++; if (cap_vec !== exp_vec || cap_n != 24) begin failures++; $display("FAIL b2b_bytes got=%h n=%0d exp=%h", cap_vec, cap_n, exp_vec); end
    checks++; if (cap_last_vec !== exp_last_vec) begin failures++; $display("FAIL b2b_last got=%h exp=%h", cap_last_vec, exp_last_vec); end
    checks++; if (valid_cycles != 24 || span != 24) begin failures++; $display("FAIL b2b_no_gap got=%0d/%0d exp=24/24", valid_cycles, span); end
    checks++; if (irdy_pulses != 3 || irdy_err != 0) begin failures++; $display("FAIL b2b_in_ready got=%0d/%0d exp=3/0", irdy_pulses, irdy_err); end
  endtask

  task automatic test_no_checksum();
    logic [7:0] got [8];
    logic       gl [8];
    int nb;
    nb = 0;
    for (int i = 0; i < 8; i++) begin got[i] = 8'hxx; gl[i] = 1'b0; end
    @(negedge clk);
    ifb.in_valid = 1'b1; ifb.x = 16'd0; ifb.y = 16'd0; ifb.t = 16'd0; ifb.p = 1'b0; ifb.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      ifb.in_valid = 1'b0;
      if (ifb.out_valid) begin
        if (nb < 8) begin got[nb] = ifb.out_data; gl[nb] = ifb.out_last; end
        nb++;
        if (ifb.out_last) break;
      end
    end
    @(negedge clk);
    ifb.out_ready = 1'b0;
    checks++; if (nb != 7) begin failures++; $display("FAIL nochk_nbytes got=%0d exp=7", nb); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (got[i] !== model_byte(16'd0, 16'd0, 16'd0, 1'b0, i) || gl[i] !== (i == 6)) begin
        failures++;
        $display("FAIL nochk_byte%0d got=%h last=%b exp=%h last=%b", i, got[i], gl[i], model_byte(16'd0, 16'd0, 16'd0, 1'b0, i), (i == 6));
      end
    end
    checks++; if (cnt_b !== 16'd1 || ifb.out_valid !== 1'b0) begin failures++; $display("FAIL nochk_done got=%0d/%b exp=1/0", cnt_b, ifb.out_valid); end
  endtask

  task automatic test_midrun_reset();
    int seen;
    bit saw_last, hit;
    logic [15:0] xr, yr, tr;
    seen = 0; saw_last = 1'b0; hit = 1'b0;
    xr = 16'($urandom); yr = 16'($urandom); tr = 16'($urandom);
    @(negedge clk);
    ifa.in_valid = 1'b1; ifa.x = xr; ifa.y = yr; ifa.t = tr; ifa.p = 1'b1; ifa.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      ifa.in_valid = 1'b0;
      if (ifa.out_valid) begin
        if (ifa.out_last) saw_last = 1'b1;
        if (seen == 3) begin hit = 1'b1; break; end
        seen++;
      end
    end
    checks++; if (!hit || ifa.out_data !== model_byte(xr, yr, tr, 1'b1, 3)) begin failures++; $display("FAIL mid_idx3 got=%h reached=%b exp=%h", ifa.out_data, hit, model_byte(xr, yr, tr, 1'b1, 3)); end
    rst = 1'b1;
    #1;
    checks++; if (ifa.out_valid !== 1'b0 || busy_a !== 1'b0 || ifa.out_data !== 8'h00) begin failures++; $display("FAIL mid_rst_outputs got=%b%b%h exp=0000", ifa.out_valid, busy_a, ifa.out_data); end
    checks++; if (cnt_a !== 16'd0 || ifa.in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_count_ready got=%0d/%b exp=0/0", cnt_a, ifa.in_ready); end
    repeat (2) begin
      @(negedge clk);
      if (ifa.out_last) saw_last = 1'b1;
    end
    rst = 1'b0;
    ifa.out_ready = 1'b0;
    #1;
    checks++; if (saw_last) begin failures++; $display("FAIL mid_no_last got=1 exp=0"); end
    checks++; if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0) begin failures++; $display("FAIL mid_idle_after got=%b%b exp=10", ifa.in_ready, ifa.out_valid); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut_a.r_pkt_count = 16'hFFFF;
    #1;
    release dut_a.r_pkt_count;
    #1;
    checks++; if (cnt_a !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", cnt_a); end
    rand_events(1);
    drive_a(1, 100);
    build_exp(1, 8);
    checks++; if (timeout || cap_vec !== exp_vec) begin failures++; $display("FAIL wrap_bytes got=%h exp=%h", cap_vec, exp_vec); end
    checks++; if (cnt_a !== 16'd0) begin failures++; $display("FAIL wrap_pkt_count got=%h exp=0000", cnt_a); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_no_checksum();
    test_midrun_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
